// File: rtl/hsx_pkg.sv
// hsx_pkg: shared constants for the HSL/HSV to RGB pipeline
package hsx_pkg;
  localparam logic MODE_HSL = 1'b0;
  localparam logic MODE_HSV = 1'b1;
  // hue sectors, named after the channel pair that leads in each sixth of the turn
  localparam logic [2:0] SEC_RED = 3'd0;
  localparam logic [2:0] SEC_YEL = 3'd1;
  localparam logic [2:0] SEC_GRN = 3'd2;
  localparam logic [2:0] SEC_CYN = 3'd3;
  localparam logic [2:0] SEC_BLU = 3'd4;
  localparam logic [2:0] SEC_MAG = 3'd5;
endpackage

// File: rtl/hsx_stage_reg.sv
// hsx_stage_reg: valid/ready pipeline register; loads when empty or when its content leaves
module hsx_stage_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);
  logic         v_q, v_d;
  logic [W-1:0] d_q, d_d;
  always_comb begin
    in_ready = ~v_q | out_ready;
    v_d = (in_valid & in_ready) | (v_q & ~out_ready);
    d_d = (in_valid & in_ready) ? in_data : d_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      v_q <= 1'b0;
      d_q <= '0;
    end else begin
      v_q <= v_d;
      d_q <= d_d;
    end
  assign out_valid = v_q;
  assign out_data  = d_q;
endmodule

// File: rtl/hsx_to_rgb_pipe.sv
// hsx_to_rgb_pipe: 3-stage HSL/HSV to RGB converter with valid/ready flow control
// and saturating output addition; the tag rides along unmodified.
module hsx_to_rgb_pipe import hsx_pkg::*; #(
  parameter int HUE_DEPTH = 8,
  parameter int SAT_DEPTH = 8,
  parameter int RGB_DEPTH = 8,
  parameter int TAG_WIDTH = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_mode,
  input  logic [HUE_DEPTH-1:0] in_h,
  input  logic [SAT_DEPTH-1:0] in_s,
  input  logic [RGB_DEPTH-1:0] in_l,
  input  logic [TAG_WIDTH-1:0] in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [RGB_DEPTH-1:0] out_r,
  output logic [RGB_DEPTH-1:0] out_g,
  output logic [RGB_DEPTH-1:0] out_b,
  output logic [TAG_WIDTH-1:0] out_tag
);
  localparam int W1 = 1 + TAG_WIDTH + 3 + HUE_DEPTH + 1 + 2 * RGB_DEPTH;
  localparam int W2 = TAG_WIDTH + 3 + 3 * RGB_DEPTH;
  localparam int W3 = TAG_WIDTH + 3 * RGB_DEPTH;

  function automatic logic [RGB_DEPTH-1:0] sat_add(input logic [RGB_DEPTH-1:0] a,
                                                   input logic [RGB_DEPTH-1:0] b);
    logic [RGB_DEPTH:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[RGB_DEPTH] ? '1 : s[RGB_DEPTH-1:0];
  endfunction

  logic [HUE_DEPTH+2:0] h6;
  logic [RGB_DEPTH:0]   l2, lx;
  logic [RGB_DEPTH-1:0] c1;
  logic [W1-1:0]        p1_d, p1_q;
  logic                 v1, v2, rdy2, rdy3;
  logic                 mode1;
  logic [TAG_WIDTH-1:0] tag1, tag2;
  logic [2:0]           sec1, sec2;
  logic [HUE_DEPTH:0]   h6m1, xf;
  logic [RGB_DEPTH-1:0] l1, cc1, x2d, m2d, c2, x2, m2, rc, gc, bc, r3, g3, b3;
  logic [W2-1:0]        p2_d, p2_q;
  logic [W3-1:0]        p3_d;

  always_comb begin
    h6 = {1'b0, in_h, 2'b00} + {2'b00, in_h, 1'b0};
    l2 = {in_l, 1'b0};
    lx = (in_mode == MODE_HSV) ? {1'b0, in_l} : in_l[RGB_DEPTH-1] ? -l2 : l2;
    c1 = RGB_DEPTH'(({{SAT_DEPTH{1'b0}}, lx} * {{(RGB_DEPTH+1){1'b0}}, in_s}) >> SAT_DEPTH);
    p1_d = {in_mode, in_tag, h6[HUE_DEPTH+2:HUE_DEPTH], h6[HUE_DEPTH:0], in_l, c1};
  end

  hsx_stage_reg #(.W(W1)) u_s1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(p1_d),
    .out_valid(v1), .out_ready(rdy2), .out_data(p1_q)
  );

  assign {mode1, tag1, sec1, h6m1, l1, cc1} = p1_q;

  always_comb begin
    xf = h6m1[HUE_DEPTH] ? -h6m1 : h6m1;
    x2d = RGB_DEPTH'(({{(HUE_DEPTH+1){1'b0}}, cc1} * {{RGB_DEPTH{1'b0}}, xf}) >> HUE_DEPTH);
    m2d = (mode1 == MODE_HSL) ? l1 - (cc1 >> 1) : l1 - cc1;
    p2_d = {tag1, sec1, cc1, x2d, m2d};
  end

  hsx_stage_reg #(.W(W2)) u_s2 (
    .clk(clk), .rst_n(rst_n), .in_valid(v1), .in_ready(rdy2), .in_data(p2_d),
    .out_valid(v2), .out_ready(rdy3), .out_data(p2_q)
  );

  assign {tag2, sec2, c2, x2, m2} = p2_q;

  always_comb begin
    rc = (sec2 == SEC_RED || sec2 == SEC_MAG) ? c2 : (sec2 == SEC_YEL || sec2 == SEC_BLU) ? x2 : '0;
    gc = (sec2 == SEC_YEL || sec2 == SEC_GRN) ? c2 : (sec2 == SEC_RED || sec2 == SEC_CYN) ? x2 : '0;
    bc = (sec2 == SEC_CYN || sec2 == SEC_BLU) ? c2 : (sec2 == SEC_GRN || sec2 == SEC_MAG) ? x2 : '0;
    r3 = (sec2 <= SEC_MAG) ? sat_add(rc, m2) : '0;
    g3 = (sec2 <= SEC_MAG) ? sat_add(gc, m2) : '0;
    b3 = (sec2 <= SEC_MAG) ? sat_add(bc, m2) : '0;
    p3_d = {tag2, r3, g3, b3};
  end

  hsx_stage_reg #(.W(W3)) u_s3 (
    .clk(clk), .rst_n(rst_n), .in_valid(v2), .in_ready(rdy3), .in_data(p3_d),
    .out_valid(out_valid), .out_ready(out_ready), .out_data({out_tag, out_r, out_g, out_b})
  );
endmodule

// File: tb/tb_hsx_to_rgb_pipe.sv
// tb_hsx_to_rgb_pipe: directed self-checking bench for hsx_to_rgb_pipe
module tb_hsx_to_rgb_pipe;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0, in_ready, in_mode = 1'b0;
  logic [7:0] in_h = '0, in_s = '0, in_l = '0;
  logic [0:0] in_tag = '0, out_tag;
  logic       out_valid, out_ready = 1'b1;
  logic [7:0] out_r, out_g, out_b;
  int checks = 0, failures = 0;

  hsx_to_rgb_pipe dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
    .in_h(in_h), .in_s(in_s), .in_l(in_l), .in_tag(in_tag), .out_valid(out_valid),
    .out_ready(out_ready), .out_r(out_r), .out_g(out_g), .out_b(out_b), .out_tag(out_tag)
  );

  always #5 clk = ~clk;

  function automatic logic [23:0] model(input logic mode, input int h, input int s, input int l);
    int h6, sec, h6m, lp, c, xf, x, m, r, g, b;
    h6 = h * 6; sec = h6 / 256; h6m = h6 % 512;
    lp = mode ? l : (l < 128 ? 2 * l : 512 - 2 * l);
    c = (lp * s) / 256;
    xf = (h6m >= 256) ? 512 - h6m : h6m;
    x = (c * xf) / 256;
    m = mode ? l - c : l - c / 2;
    case (sec)
      0: begin r = c; g = x; b = 0; end
      1: begin r = x; g = c; b = 0; end
      2: begin r = 0; g = c; b = x; end
      3: begin r = 0; g = x; b = c; end
      4: begin r = x; g = 0; b = c; end
      default: begin r = c; g = 0; b = x; end
    endcase
    r = (r + m > 255) ? 255 : r + m;
    g = (g + m > 255) ? 255 : g + m;
    b = (b + m > 255) ? 255 : b + m;
    return {r[7:0], g[7:0], b[7:0]};
  endfunction

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({out_valid, out_tag, out_r, out_g, out_b} !== 26'd0)
      begin failures++; $display("FAIL reset_outputs got=%h exp=0", {out_valid, out_tag, out_r, out_g, out_b}); end
    rst_n = 1'b1;
    @(negedge clk); #1;
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_directed();
    logic       vm[4]  = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic [7:0] vh[4]  = '{8'd0, 8'd128, 8'd0, 8'd0};
    logic [7:0] vl[4]  = '{8'd127, 8'd127, 8'd255, 8'd200};
    logic [24:0] ve[4] = '{{1'b0, 8'd254, 8'd1, 8'd1}, {1'b1, 8'd1, 8'd254, 8'd254},
                           {1'b0, 8'd255, 8'd255, 8'd255}, {1'b1, 8'd200, 8'd1, 8'd1}};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      out_ready = 1'b1; in_valid = 1'b1; in_mode = vm[i]; in_h = vh[i]; in_s = 8'd255; in_l = vl[i];
      in_tag = ve[i][24];
      #1;
      checks++;
      if (in_ready !== 1'b1) begin failures++; $display("FAIL dir%0d_in_ready got=%b exp=1", i, in_ready); end
      @(negedge clk); in_valid = 1'b0; #1;
      checks++;
      if (out_valid !== 1'b0) begin failures++; $display("FAIL dir%0d_early1 got=%b exp=0", i, out_valid); end
      @(negedge clk); #1;
      checks++;
      if (out_valid !== 1'b0) begin failures++; $display("FAIL dir%0d_early2 got=%b exp=0", i, out_valid); end
      @(negedge clk); #1;
      checks++;
      if ({out_valid, out_tag, out_r, out_g, out_b} !== {1'b1, ve[i]})
        begin failures++; $display("FAIL dir%0d_result got=%h exp=%h", i, {out_valid, out_tag, out_r, out_g, out_b}, {1'b1, ve[i]}); end
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_mixed();
    logic [7:0] vh[8] = '{8'd0, 8'd43, 8'd85, 8'd170, 8'd200, 8'd255, 8'd128, 8'd21};
    logic [7:0] vs[8] = '{8'd255, 8'd200, 8'd128, 8'd255, 8'd100, 8'd50, 8'd255, 8'd255};
    logic [7:0] vl[8] = '{8'd127, 8'd180, 8'd60, 8'd255, 8'd200, 8'd90, 8'd128, 8'd10};
    logic [24:0] q[$];
    logic [24:0] e;
    int sent = 0, got = 0;
    for (int cyc = 0; cyc < 100 && got < 8; cyc++) begin
      @(negedge clk);
      out_ready = 1'b1; in_valid = (sent < 8);
      in_mode = sent[0]; in_tag = sent[1];
      in_h = vh[sent % 8]; in_s = vs[sent % 8]; in_l = vl[sent % 8];
      #1;
      if (out_valid && out_ready) begin
        e = (q.size() != 0) ? q.pop_front() : 25'h1ffffff;
        checks++;
        if ({out_tag, out_r, out_g, out_b} !== e)
          begin failures++; $display("FAIL mixed%0d got=%h exp=%h", got, {out_tag, out_r, out_g, out_b}, e); end
        got++;
      end
      if (in_valid && in_ready) begin q.push_back({in_tag, model(in_mode, in_h, in_s, in_l)}); sent++; end
    end
    in_valid = 1'b0;
    checks++;
    if (got != 8) begin failures++; $display("FAIL mixed_count got=%0d exp=8", got); end
  endtask

  task automatic test_stall_fill();
    logic [24:0] q[$];
    logic [24:0] e;
    int acc = 0, got = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      out_ready = 1'b0; in_valid = 1'b1; in_mode = 1'b0;
      in_h = 8'(k * 40 + acc); in_s = 8'd255; in_l = 8'd100; in_tag = in_h[0];
      #1;
      if (in_ready) begin q.push_back({in_tag, model(in_mode, in_h, in_s, in_l)}); acc++; end
    end
    checks++;
    if (acc != 3) begin failures++; $display("FAIL stall_accepts got=%0d exp=3", acc); end
    checks++;
    if (in_ready !== 1'b0) begin failures++; $display("FAIL stall_in_ready got=%b exp=0", in_ready); end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    for (int cyc = 0; cyc < 20 && got < acc; cyc++) begin
      #1;
      if (out_valid) begin
        e = (q.size() != 0) ? q.pop_front() : 25'h1ffffff;
        checks++;
        if ({out_tag, out_r, out_g, out_b} !== e)
          begin failures++; $display("FAIL stall_drain%0d got=%h exp=%h", got, {out_tag, out_r, out_g, out_b}, e); end
        got++;
      end
      @(negedge clk);
    end
    checks++;
    if (got != 3) begin failures++; $display("FAIL stall_drain_count got=%0d exp=3", got); end
  endtask

  task automatic test_back_to_back();
    logic [24:0] q[$];
    logic [24:0] e, held;
    logic held_v = 1'b0;
    int sent = 0, got = 0;
    for (int cyc = 0; cyc < 4000 && got < 256; cyc++) begin
      @(negedge clk);
      out_ready = ($urandom_range(0, 2) != 0);
      in_valid = (sent < 256); in_mode = 1'b0;
      in_h = sent[7:0]; in_s = 8'd255; in_l = sent[7:0] ^ 8'h5a; in_tag = sent[0];
      #1;
      if (held_v) begin
        checks++;
        if ({out_valid, out_tag, out_r, out_g, out_b} !== {1'b1, held})
          begin failures++; $display("FAIL bp_hold got=%h exp=%h", {out_valid, out_tag, out_r, out_g, out_b}, {1'b1, held}); end
      end
      if (out_valid && out_ready) begin
        e = (q.size() != 0) ? q.pop_front() : 25'h1ffffff;
        checks++;
        if ({out_tag, out_r, out_g, out_b} !== e)
          begin failures++; $display("FAIL bp_pixel%0d got=%h exp=%h", got, {out_tag, out_r, out_g, out_b}, e); end
        got++;
      end
      held_v = out_valid && !out_ready;
      held = {out_tag, out_r, out_g, out_b};
      if (in_valid && in_ready) begin q.push_back({in_tag, model(in_mode, in_h, in_s, in_l)}); sent++; end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    checks++;
    if (got != 256 || q.size() != 0)
      begin failures++; $display("FAIL bp_count got=%0d left=%0d exp=256/0", got, q.size()); end
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      out_ready = 1'b0; in_valid = 1'b1; in_mode = 1'b0; in_h = 8'(k * 60); in_s = 8'd255; in_l = 8'd127; in_tag = 1'b1;
    end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b1) begin failures++; $display("FAIL mid_filled got=%b exp=1", out_valid); end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, out_tag, out_r, out_g, out_b} !== 26'd0)
      begin failures++; $display("FAIL mid_reset got=%h exp=0", {out_valid, out_tag, out_r, out_g, out_b}); end
    @(negedge clk);
    rst_n = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b1; in_mode = 1'b1; in_h = 8'd0; in_s = 8'd255; in_l = 8'd200; in_tag = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL mid_in_ready got=%b exp=1", in_ready); end
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      checks++;
      if (k < 3 && out_valid !== 1'b0) begin failures++; $display("FAIL mid_stale%0d got=%b exp=0", k, out_valid); end
      if (k == 3 && {out_valid, out_tag, out_r, out_g, out_b} !== {1'b1, 1'b0, 8'd200, 8'd1, 8'd1})
        begin failures++; $display("FAIL mid_new got=%h exp=%h", {out_valid, out_tag, out_r, out_g, out_b}, {1'b1, 1'b0, 8'd200, 8'd1, 8'd1}); end
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_mixed();
    test_stall_fill();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
